counter_step_checker: RTL and testbench

Receive-side monitor for the even/odd up/down counter. Samples the counter's 8-bit output stream and recovers the stepping direction, locking once enough consecutive ±1 steps are seen. After lock it flags every sample that breaks the recovered sequence and enters a sticky fault after repeated consecutive breaks. It sits downstream of the counter, on the same clock, as a self-check and observability block.

---
 rtl/counter_step_checker.sv | 130 +++++++++++++
 tb/tb_counter_step_checker.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/counter_step_checker.sv
// Step-direction monitor for the even/odd up/down counter stream.
// Ports: clk, rst_n (sync, active-low), clr, in_valid, q_in, mode_a -> locked, dir_up, err_pulse, err_count, fault. Optional feature: PARITY_CHECK_EN.
module counter_step_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] mode_a,
  output logic             locked,
  output logic             dir_up,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic             fault
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE, ACQ, LOCKED, FAULT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [RW-1:0]    run;
  logic [MW-1:0]    miss;
  logic             cand;

  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] exp_val;
  logic             is_up;
  logic             is_dn;
  logic             up_ok;
  logic             dn_ok;
  logic             step_ok;
  logic             match;
  logic [RW-1:0]    run_next;
  logic [MW-1:0]    miss_next;

  always_comb begin
    diff    = q_in - prev;
    is_up   = (diff == WIDTH'(1));
    is_dn   = (diff == {WIDTH{1'b1}});
    exp_val = dir_up ? prev + WIDTH'(1)
                     : prev - WIDTH'(1);
`ifdef PARITY_CHECK_EN
    // mode_a[0]=0 demands up, =1 demands down
    up_ok = is_up && !mode_a[0];
    dn_ok = is_dn && mode_a[0];
    match = (q_in == exp_val) &&
            (dir_up != mode_a[0]);
`else
    up_ok = is_up;
    dn_ok = is_dn;
    match = (q_in == exp_val);
`endif
    step_ok  = up_ok | dn_ok;
    run_next = '0;
    // a reversal (or the first step) restarts the run at 1
    if (step_ok) begin
      if (run != '0 && cand == up_ok)
        run_next = run + RW'(1);
      else
        run_next = RW'(1);
    end
    miss_next = miss + MW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state     <= IDLE;
      prev      <= '0;
      run       <= '0;
      miss      <= '0;
      cand      <= 1'b0;
      locked    <= 1'b0;
      dir_up    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      fault     <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        unique case (state)
          IDLE: begin
            prev  <= q_in;
            run   <= '0;
            state <= ACQ;
          end
          ACQ: begin
            prev <= q_in;
            run  <= run_next;
            if (step_ok)
              cand <= up_ok;
            if (run_next == RW'(LOCK_COUNT)) begin
              state  <= LOCKED;
              locked <= 1'b1;
              dir_up <= up_ok;
              miss   <= '0;
            end
          end
          LOCKED: begin
            prev <= q_in;
            if (match) begin
              miss <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
              miss <= miss_next;
              if (miss_next == MW'(ERR_LIMIT)) begin
                state  <= FAULT;
                fault  <= 1'b1;
                locked <= 1'b0;
              end
            end
          end
          FAULT: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_step_checker.sv
// Scoreboard bench for counter_step_checker.
// Driver queues expected outputs; monitor pops and compares after each edge.
module tb_counter_step_checker;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] q_in;
  logic [7:0] mode_a;
  logic       locked;
  logic       dir_up;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       fault;

  typedef struct {
    string      nm;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  counter_step_checker #(
    .WIDTH(8),
    .LOCK_COUNT(4),
    .ERR_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .in_valid(in_valid),
    .q_in(q_in),
    .mode_a(mode_a),
    .locked(locked),
    .dir_up(dir_up),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    exp_t e;
    logic [11:0] act;
    #1;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {locked, dir_up, err_pulse,
             err_count, fault};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s got lk=%b up=%b ep=%b ec=%0d ft=%b want lk=%b up=%b ep=%b ec=%0d ft=%b",
          e.nm, act[11], act[10], act[9],
          act[8:1], act[0], e.v[11], e.v[10],
          e.v[9], e.v[8:1], e.v[0]);
      end
    end
  end

  task automatic step(
    input logic r, input logic c,
    input logic v, input logic [7:0] d,
    input logic [7:0] m, input string nm,
    input logic lk, input logic up,
    input logic ep, input logic [7:0] ec,
    input logic ft
  );
    exp_t e;
    @(negedge clk);
    rst_n    = r;
    clr      = c;
    in_valid = v;
    q_in     = d;
    mode_a   = m;
    e.nm = nm;
    e.v  = {lk, up, ep, ec, ft};
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic s(
    input logic [7:0] d, input logic [7:0] m,
    input string nm, input logic lk,
    input logic up, input logic ep,
    input logic [7:0] ec, input logic ft
  );
    step(1, 0, 1, d, m, nm, lk, up, ep, ec, ft);
  endtask

  task automatic do_clr(input string nm);
    step(1, 1, 0, 8'h00, 8'h00, nm,
         0, 0, 0, 8'd0, 0);
  endtask

  initial begin
    int guard;
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    q_in     = 8'h00;
    mode_a   = 8'h00;

    step(0, 0, 0, 8'h00, 8'h00, "reset0",
         0, 0, 0, 8'd0, 0);
    step(0, 0, 1, 8'h33, 8'h00, "reset1",
         0, 0, 0, 8'd0, 0);

    s(8'd10, 0, "up10", 0, 0, 0, 0, 0);
    s(8'd11, 0, "up11", 0, 0, 0, 0, 0);
    s(8'd12, 0, "up12", 0, 0, 0, 0, 0);
    s(8'd13, 0, "up13", 0, 0, 0, 0, 0);
    s(8'd14, 0, "lock14", 1, 1, 0, 0, 0);
    s(8'd15, 0, "trk15", 1, 1, 0, 0, 0);

    do_clr("clr1");
    s(8'd16, 0, "a16", 0, 0, 0, 0, 0);
    s(8'd17, 0, "a17", 0, 0, 0, 0, 0);
    s(8'd18, 0, "a18", 0, 0, 0, 0, 0);
    s(8'd19, 0, "a19", 0, 0, 0, 0, 0);
    s(8'd20, 0, "lock20", 1, 1, 0, 0, 0);
    s(8'd21, 0, "m21", 1, 1, 0, 0, 0);
    s(8'd40, 0, "miss40", 1, 1, 1, 1, 0);
    s(8'd41, 0, "resync41", 1, 1, 0, 1, 0);
    s(8'd50, 0, "miss50a", 1, 1, 1, 2, 0);
    s(8'd50, 0, "miss50b", 1, 1, 1, 3, 0);
    s(8'd50, 0, "fault50", 0, 1, 1, 4, 1);
    s(8'd51, 0, "hold51", 0, 1, 0, 4, 1);
    step(1, 0, 0, 8'd52, 0, "holdnv",
         0, 1, 0, 8'd4, 1);
    do_clr("clr2");

    s(8'd4, 1, "d4", 0, 0, 0, 0, 0);
    s(8'd3, 1, "d3", 0, 0, 0, 0, 0);
    s(8'd2, 1, "d2", 0, 0, 0, 0, 0);
    s(8'd1, 1, "d1", 0, 0, 0, 0, 0);
    s(8'd0, 1, "lock0", 1, 0, 0, 0, 0);
    s(8'hFF, 1, "wrapFF", 1, 0, 0, 0, 0);
    s(8'hFE, 1, "dFE", 1, 0, 0, 0, 0);
    step(1, 0, 0, 8'h80, 1, "idle_nv",
         1, 0, 0, 8'd0, 0);
    s(8'hFD, 1, "dFD", 1, 0, 0, 0, 0);

    step(1, 1, 1, 8'd77, 0, "clr_wins",
         0, 0, 0, 8'd0, 0);
    s(8'd5, 0, "r5", 0, 0, 0, 0, 0);
    s(8'd6, 0, "r6", 0, 0, 0, 0, 0);
    s(8'd5, 0, "r5b", 0, 0, 0, 0, 0);
    s(8'd6, 0, "r6b", 0, 0, 0, 0, 0);
    s(8'd7, 0, "r7", 0, 0, 0, 0, 0);
    s(8'd8, 0, "r8", 0, 0, 0, 0, 0);
    s(8'd9, 0, "lock9", 1, 1, 0, 0, 0);
    s(8'd30, 0, "miss30", 1, 1, 1, 1, 0);
    step(0, 1, 1, 8'd31, 0, "rst_mid",
         0, 0, 0, 8'd0, 0);
    s(8'd56, 0, "post_rst", 0, 0, 0, 0, 0);

`ifdef PARITY_CHECK_EN
    do_clr("clr3");
    s(8'd10, 3, "p10", 0, 0, 0, 0, 0);
    s(8'd11, 3, "p11", 0, 0, 0, 0, 0);
    s(8'd12, 3, "p12", 0, 0, 0, 0, 0);
    s(8'd13, 3, "p13", 0, 0, 0, 0, 0);
    s(8'd14, 3, "p14", 0, 0, 0, 0, 0);
    s(8'd14, 3, "p14b", 0, 0, 0, 0, 0);
    s(8'd13, 3, "p13d", 0, 0, 0, 0, 0);
    s(8'd12, 3, "p12d", 0, 0, 0, 0, 0);
    s(8'd11, 3, "p11d", 0, 0, 0, 0, 0);
    s(8'd10, 3, "plock10", 1, 0, 0, 0, 0);
    s(8'd9, 2, "pmode9", 1, 0, 1, 1, 0);
`endif

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0",
               sb.size());
    end
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
